// File: rtl/sp_fifo_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller and its wrapper.
// The RAM operation encoding and the depth helper live here.
package sp_fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/sp_fifo.sv
// Complete FIFO: the controller bound to a single-port RAM through the mem_* ports.
module sp_fifo
  import sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  sp_fifo_ctrl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  sp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: rtl/sp_ram.sv
// Single-port RAM: clocked write, combinational read on the shared address.
module sp_ram
  import sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] ram_q [0:DEPTH-1];

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      ram_q[addr] <= wdata;
    end
  end

  assign rdata = ram_q[addr];

endmodule

// File: rtl/sp_fifo_ctrl.sv
// FIFO controller for a single-port RAM: one RAM access per cycle, refills of the
// registered head word take priority over pushes.
module sp_fifo_ctrl
  import sp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  rd_cond;
  op_e                   op;

  // Arbitrate the single RAM port; a pending refill always wins over a push.
  always_comb begin
    rd_cond  = (mem_count_q != CNT_ZERO) && (!out_valid_q || out_ready);
    in_ready = !reset && !clear && (mem_count_q != DEPTH_CNT) && !rd_cond;
    if (reset || clear) begin
      op = OP_NONE;
    end else if (rd_cond) begin
      op = OP_READ;
    end else if (in_valid && in_ready) begin
      op = OP_WRITE;
    end else begin
      op = OP_NONE;
    end
    mem_wdata = in_data;
    case (op)
      OP_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = wr_ptr_q;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = rd_ptr_q;
      end
    endcase
  end

  // Next-state for pointers, occupancy and the head register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear) begin
      wr_ptr_d    = PTR_ZERO;
      rd_ptr_d    = PTR_ZERO;
      mem_count_d = CNT_ZERO;
      out_valid_d = 1'b0;
    end else begin
      // A pop empties the head unless the same edge refills it.
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      case (op)
        OP_READ: begin
          out_data_d  = mem_rdata;
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          mem_count_d = mem_count_q - CNT_ONE;
        end
        OP_WRITE: begin
          wr_ptr_d    = wr_ptr_q + PTR_ONE;
          mem_count_d = mem_count_q + CNT_ONE;
        end
        default: begin
          mem_count_d = mem_count_q;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      mem_count_q <= CNT_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = mem_count_q + {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign full      = (mem_count_q == DEPTH_CNT);
  assign empty     = (level == CNT_ZERO);

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Randomized and directed bench for sp_fifo_ctrl against a queue-based reference model;
// the sp_fifo wrapper runs alongside on the same stimulus.
module tb_sp_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset, clear, in_valid, in_ready, out_valid, out_ready, mem_we, full, empty;
  logic [7:0] in_data, out_data, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;
  logic [4:0] level;
  logic       w_in_ready, w_out_valid, w_full, w_empty;
  logic [7:0] w_out_data;
  logic [4:0] w_level;

  logic [7:0] ram  [16];
  logic [7:0] snap [16];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: RAM-resident words as a queue plus the head register.
  logic [7:0] m_q[$];
  logic [7:0] popped[$];
  logic       m_ov;
  logic [7:0] m_od;
  int         m_wp, m_rp;
  logic       m_rd, m_ir, m_we;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  sp_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .level(level), .full(full), .empty(empty)
  );

  sp_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .level(w_level), .full(w_full), .empty(w_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ov = 1'b0;
    m_od = 8'h00;
    m_wp = 0;
    m_rp = 0;
  endtask

  task automatic compare_comb();
    int sz;
    sz   = m_q.size();
    m_rd = (sz > 0) && (!m_ov || out_ready);
    m_ir = !reset && !clear && (sz < 16) && !m_rd;
    m_we = in_valid && m_ir;
    check("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
    check("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    check("mem_addr", {28'd0, mem_addr}, m_we ? m_wp : m_rp);
    if (m_we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, in_data});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("out_data", {24'd0, out_data}, {24'd0, m_od});
    check("level", {27'd0, level}, sz + int'(m_ov));
    check("full", {31'd0, full}, {31'd0, sz == 16});
    check("empty", {31'd0, empty}, {31'd0, (sz == 0) && !m_ov});
    check("w_in_ready", {31'd0, w_in_ready}, {31'd0, m_ir});
    check("w_out_valid", {31'd0, w_out_valid}, {31'd0, m_ov});
    check("w_out_data", {24'd0, w_out_data}, {24'd0, m_od});
    check("w_level", {27'd0, w_level}, sz + int'(m_ov));
    check("w_full", {31'd0, w_full}, {31'd0, sz == 16});
    check("w_empty", {31'd0, w_empty}, {31'd0, (sz == 0) && !m_ov});
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (clear) begin
      m_q.delete();
      m_ov = 1'b0;
      m_wp = 0;
      m_rp = 0;
    end else begin
      if (m_ov && out_ready) begin
        popped.push_back(m_od);
        m_ov = 1'b0;
      end
      if (m_rd) begin
        m_od = m_q.pop_front();
        m_ov = 1'b1;
        m_rp = (m_rp + 1) % 16;
      end else if (m_we) begin
        m_q.push_back(in_data);
        m_wp = (m_wp + 1) % 16;
      end
    end
  endtask

  // One clock cycle: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clock);
    compare_comb();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    int acc;
    int toggles;
    logic prev_ir;
    int diffs;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    model_reset();
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Single push latency.
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    check("a5_c0_we", {31'd0, mem_we}, 32'd1);
    check("a5_c0_addr", {28'd0, mem_addr}, 32'd0);
    step();
    in_valid = 1'b0;
    #1;
    check("a5_c1_we", {31'd0, mem_we}, 32'd0);
    check("a5_c1_addr", {28'd0, mem_addr}, 32'd0);
    check("a5_level", {27'd0, level}, 32'd1);
    check("a5_c1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("a5_valid", {31'd0, out_valid}, 32'd1);
    check("a5_data", {24'd0, out_data}, 32'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Fill to capacity with out_ready low.
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_data = acc[7:0];
      step();
      if (m_we) acc++;
    end
    in_data = 8'h11;
    #1;
    check("fill_count", acc, 32'd17);
    check("fill_level", {27'd0, level}, 32'd17);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    popped.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("drain_count", popped.size(), 32'd17);
    for (int i = 0; i < popped.size(); i++) check("drain_order", {24'd0, popped[i]}, i);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Streaming with both sides active across pointer wraps.
    popped.delete();
    acc = 0; toggles = 0; prev_ir = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = acc[7:0];
      step();
      if (m_we) acc++;
      if (i > 2 && m_ir != prev_ir) toggles++;
      prev_ir = m_ir;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < popped.size(); i++) check("stream_order", {24'd0, popped[i]}, i);
    check("stream_enough", {31'd0, popped.size() >= 40}, 32'd1);
    check("stream_alternate", {31'd0, toggles >= 80}, 32'd1);
    out_ready = 1'b0;

    // Synchronous clear with five words held and a push pending.
    acc = 0;
    in_valid = 1'b1;
    while (acc < 5) begin
      in_data = 8'h80 + acc[7:0];
      step();
      if (m_we) acc++;
    end
    check("pre_clear_level", {27'd0, level}, 32'd5);
    clear = 1'b1;
    #1;
    check("clr_we", {31'd0, mem_we}, 32'd0);
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    check("clr_level", {27'd0, level}, 32'd0);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_empty", {31'd0, empty}, 32'd1);
    in_valid = 1'b1; in_data = 8'h3C;
    #1;
    check("3c_wr_addr", {28'd0, mem_addr}, 32'd0);
    check("3c_we", {31'd0, mem_we}, 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check("3c_rd_addr", {28'd0, mem_addr}, 32'd0);
    step();
    check("3c_data", {24'd0, out_data}, 32'h3C);
    check("3c_valid", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset mid-cycle with a pending push.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h50 + i[7:0];
      step();
    end
    in_data = 8'h77;
    #1;
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_we", {31'd0, mem_we}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd0);
    check("ar_level", {27'd0, level}, 32'd0);
    for (int i = 0; i < 16; i++) snap[i] = ram[i];
    @(posedge clock);
    #1;
    diffs = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== snap[i]) diffs++;
    check("ar_no_write", diffs, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    step();
    check("ar_post_level", {27'd0, level}, 32'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      in_data   = 8'($urandom_range(0, 255));
      step();
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("final_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sp_fifo_ctrl.md
# sp_fifo_ctrl

FIFO controller that drives a single-port RAM with combinational read and clocked write: 8-bit data, 16 words by default. It is the upstream stage of the RAM. It converts a valid/ready push stream and a valid/ready pop stream into the RAM's single address, write-enable and write-data signals. A one-word output register holds the head of the FIFO, so the shared address can be used for writes while data is presented downstream.

## Interface
- DATA_WIDTH, 8, word width
- ADDR_WIDTH, 4, RAM address width; DEPTH = 1<<ADDR_WIDTH RAM words
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush
- in_valid  in  1  push request
- in_ready  out  1  push accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  push word
- out_valid  out  1  head word valid
- out_ready  in  1  pop when out_valid && out_ready
- out_data  out  DATA_WIDTH  head word (registered)
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_WIDTH  RAM write data (= in_data)
- mem_rdata  in  DATA_WIDTH  RAM combinational read data
- level  out  ADDR_WIDTH+1  words held: mem_count + out_valid, 0..DEPTH+1
- full  out  1  mem_count == DEPTH
- empty  out  1  level == 0

## Operation
- State registers:
  - wr_ptr, rd_ptr: ADDR_WIDTH bits, wrap modulo DEPTH
  - mem_count: 0..DEPTH
  - out_valid and out_data register
- Exactly one RAM operation per cycle, chosen combinationally:
  - OP_READ when mem_count>0 && (!out_valid || out_ready)
  - else OP_WRITE when in_valid && in_ready
  - else OP_NONE
- in_ready = !reset && !clear && mem_count<DEPTH && !(read condition). in_ready may depend combinationally on out_ready.
- OP_WRITE:
  - mem_addr=wr_ptr, mem_we=1
  - at the edge: wr_ptr+1, mem_count+1
- OP_READ / OP_NONE: mem_addr=rd_ptr, mem_we=0.
- OP_READ edge: out_data<=mem_rdata, out_valid<=1, rd_ptr+1, mem_count-1.
- Pop without refill: out_valid<=0; out_data keeps its value.
- No bypass: a pushed word always goes through the RAM, even when the FIFO is empty.
- clear has priority over everything:
  - in its cycle: mem_we=0, in_ready=0
  - at the edge: pointers, mem_count and out_valid go to 0; out_data is unchanged
- Overflow and underflow are impossible by construction. Total capacity is DEPTH+1 words.

## Timing
- Reset values:
  - out_valid=0, out_data=0, level=0, empty=1, full=0
  - in_ready=0, mem_we=0, mem_addr=0
  - all pointers and counters 0
- During reset, mem_we is forced 0 so no RAM write occurs on any edge while reset is high.
- Reset asserted mid-operation clears state immediately, without waiting for an edge. The RAM contents are left stale and are not read again.
- Latency into an empty FIFO: word pushed on edge N → RAM read in cycle N+1 → out_valid=1 after edge N+1 (two edges).
- Throughput with both sides active and the RAM non-empty: reads take priority, so pushes are accepted only when no refill is needed. Sustained rate is 1 word per 2 cycles; no word is lost or reordered.
- level, full and empty are derived from registers only and update on the edge after the event.
- Wrap-around: pointers roll from DEPTH-1 to 0 silently; full and empty come from mem_count, never from pointer comparison.

## Structure
- Shared package `sp_fifo_pkg`:
  - op encoding OP_NONE=2'd0, OP_WRITE=2'd1, OP_READ=2'd2
  - localparam helper DEPTH = 1<<ADDR_WIDTH
- Controller logic is flat: arbiter, pointer/count registers and output register in one module.
- One natural sub-module: `sp_fifo`, a wrapper that instantiates sp_fifo_ctrl together with the team's single-port RAM and connects the mem_* ports.

## Test plan
- Reset → out_valid=0, level=0, empty=1, mem_we=0. After release with the FIFO idle, in_ready=1.
- Push 0xA5 on edge 0, out_ready=0:
  - cycle 0: mem_we=1, mem_addr=0
  - cycle 1: mem_we=0, mem_addr=0
  - after edge 1: out_valid=1, out_data=0xA5
  - level=1 after edge 0
- Push 0x00..0x11 continuously, out_ready=0:
  - exactly 17 words accepted (0x00..0x10)
  - level=17, full=1, in_ready=0; 0x11 held off
  - then out_ready=1: 0x00..0x10 come out in order, and empty=1 after the last pop
- in_valid=1 and out_ready=1 for 100 cycles, incrementing data:
  - output sequence is strictly incrementing across several pointer wraps
  - in_ready alternates once the RAM is non-empty
- With level=5 and in_valid=1, assert clear for 1 cycle:
  - in that cycle mem_we=0, in_ready=0
  - after the edge level=0, out_valid=0, empty=1
  - next push 0x3C is read from RAM address 0
- Assert reset asynchronously mid-cycle with out_valid=1 and a pending push:
  - out_valid falls before the next edge
  - no RAM write on that edge
  - after release, level=0
